// File: rtl/test_pattern_gen.sv
// Video test-pattern source: six patterns selected through a valid/ready
// mode request that is applied on the next frame boundary.
module test_pattern_gen #(
  parameter int COLOR_BITS    = 8,
  parameter int BIT_WIDTH     = 10,
  parameter int BIT_HEIGHT    = 10,
  parameter int FRAME_WIDTH   = 858,
  parameter int FRAME_HEIGHT  = 525,
  parameter int SCREEN_WIDTH  = 720,
  parameter int SCREEN_HEIGHT = 480,
  parameter int CHECKER_LOG2  = 4,
  parameter int SCROLL_STEP   = 1,
  parameter int RESET_MODE    = 0
) (
  input  logic                    clk_pixel,
  input  logic                    reset_n,
  input  logic [BIT_WIDTH-1:0]    cx,
  input  logic [BIT_HEIGHT-1:0]   cy,
  input  logic [2:0]              mode_req,
  input  logic                    mode_valid,
  output logic                    mode_ready,
  input  logic [3*COLOR_BITS-1:0] solid_rgb,
  output logic [3*COLOR_BITS-1:0] rgb,
  output logic [2:0]              mode_active,
  output logic                    frame_start,
  output logic [7:0]              frame_count
);

  localparam int CW   = 3*COLOR_BITS;
  localparam int SUMW = BIT_WIDTH+1;
  localparam int YW   = (COLOR_BITS > CHECKER_LOG2+1)
                      ? COLOR_BITS : CHECKER_LOG2+1;
  localparam int SX_I = FRAME_WIDTH-SCREEN_WIDTH;
  localparam int SY_I = FRAME_HEIGHT-SCREEN_HEIGHT;

  localparam logic [BIT_WIDTH-1:0]  START_X  = BIT_WIDTH'(SX_I);
  localparam logic [BIT_HEIGHT-1:0] START_Y  = BIT_HEIGHT'(SY_I);
  localparam logic [BIT_WIDTH-1:0]  X_LAST   = BIT_WIDTH'(FRAME_WIDTH-1);
  localparam logic [BIT_HEIGHT-1:0] Y_LAST   = BIT_HEIGHT'(FRAME_HEIGHT-1);
  localparam logic [BIT_WIDTH-1:0]  BAR_LAST = BIT_WIDTH'(SCREEN_WIDTH/8-1);
  localparam logic [BIT_WIDTH-1:0]  CNT_ONE  = BIT_WIDTH'(1);
  localparam logic [SUMW-1:0]       SCR_W    = SUMW'(SCREEN_WIDTH);
  localparam logic [SUMW-1:0]       SCR_STEP = SUMW'(SCROLL_STEP);
  localparam logic [SUMW-1:0]       BAR_W    = SUMW'(8);
  localparam logic [2:0]            RST_MODE = 3'(RESET_MODE);

  localparam logic [COLOR_BITS-1:0] FULL = {COLOR_BITS{1'b1}};
  localparam logic [COLOR_BITS-1:0] ZERO = '0;
  localparam logic [CW-1:0]         WHITE = {CW{1'b1}};

  localparam logic [2:0] M_BORDER = 3'd0;
  localparam logic [2:0] M_BARS   = 3'd1;
  localparam logic [2:0] M_CHECK  = 3'd2;
  localparam logic [2:0] M_GRAD   = 3'd3;
  localparam logic [2:0] M_MOVE   = 3'd4;
  localparam logic [2:0] M_SOLID  = 3'd5;

  logic [CW-1:0]         rgb_q, rgb_d;
  logic [2:0]            mode_q, mode_d;
  logic [2:0]            pend_mode_q, pend_mode_d;
  logic                  pending_q, pending_d;
  logic                  fs_q, fs_d;
  logic [7:0]            fc_q, fc_d;
  logic [BIT_WIDTH-1:0]  scroll_q, scroll_d;
  logic [BIT_WIDTH-1:0]  bar_cnt_q, bar_cnt_d;
  logic [2:0]            bar_idx_q, bar_idx_d;

  logic                  fb;
  logic                  act_x;
  logic                  act;
  logic [BIT_WIDTH-1:0]  x;
  logic [YW-1:0]         y;
  logic [SUMW-1:0]       scroll_sum;
  logic [SUMW-1:0]       scroll_wrap;
  logic [SUMW-1:0]       xw;
  logic [SUMW-1:0]       bar_lo;
  logic [SUMW-1:0]       bar_hi;

  // {r,g,b} on/off per bar, white..black
  function automatic logic [2:0] bar_bits(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [CW-1:0] expand(input logic [2:0] b);
    return {{COLOR_BITS{b[2]}},
            {COLOR_BITS{b[1]}},
            {COLOR_BITS{b[0]}}};
  endfunction

  always_comb begin
    fb    = (cx == '0) && (cy == '0);
    act_x = (cx >= START_X);
    act   = act_x && (cy >= START_Y);
    x     = act ? cx - START_X : '0;
    y     = act ? YW'(cy - START_Y) : '0;
  end

  always_comb begin
    mode_d      = mode_q;
    pend_mode_d = pend_mode_q;
    pending_d   = pending_q;
    unique case (1'b1)
      pending_q && fb: begin
        mode_d    = pend_mode_q;
        pending_d = 1'b0;
      end
      !pending_q && mode_valid: begin
        pend_mode_d = mode_req;
        pending_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    fs_d        = fb;
    fc_d        = fb ? fc_q + 8'd1 : fc_q;
    scroll_sum  = {1'b0, scroll_q} + SCR_STEP;
    scroll_wrap = scroll_sum - SCR_W;
    scroll_d    = scroll_q;
    if (fb) begin
      scroll_d = (scroll_sum >= SCR_W)
               ? scroll_wrap[BIT_WIDTH-1:0]
               : scroll_sum[BIT_WIDTH-1:0];
    end
  end

  // bar position tracked by counting, so no divider on cx
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (!act_x) begin
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (bar_cnt_q == BAR_LAST) begin
      bar_cnt_d = '0;
      if (bar_idx_q != 3'd7) begin
        bar_idx_d = bar_idx_q + 3'd1;
      end
    end else begin
      bar_cnt_d = bar_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    xw     = {1'b0, x};
    bar_lo = {1'b0, scroll_q};
    bar_hi = bar_lo + BAR_W;
    rgb_d  = '0;
    if (mode_q == M_BORDER) begin
      rgb_d = {(cx == START_X) ? FULL : ZERO,
               (cy == START_Y) ? FULL : ZERO,
               (cx == X_LAST || cy == Y_LAST) ? FULL : ZERO};
    end else if (act) begin
      case (mode_q)
        M_BARS:  rgb_d = expand(bar_bits(bar_idx_q));
        M_CHECK: rgb_d = (x[CHECKER_LOG2] ^ y[CHECKER_LOG2])
                       ? WHITE : '0;
        M_GRAD:  rgb_d = {x[COLOR_BITS-1:0],
                          y[COLOR_BITS-1:0], ZERO};
        M_MOVE:  rgb_d = (xw >= bar_lo && xw < bar_hi)
                       ? WHITE : '0;
        M_SOLID: rgb_d = solid_rgb;
        default: rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q       <= '0;
      mode_q      <= RST_MODE;
      pend_mode_q <= '0;
      pending_q   <= 1'b0;
      fs_q        <= 1'b0;
      fc_q        <= '0;
      scroll_q    <= '0;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
    end else begin
      rgb_q       <= rgb_d;
      mode_q      <= mode_d;
      pend_mode_q <= pend_mode_d;
      pending_q   <= pending_d;
      fs_q        <= fs_d;
      fc_q        <= fc_d;
      scroll_q    <= scroll_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
    end
  end

  assign rgb         = rgb_q;
  assign mode_active = mode_q;
  assign mode_ready  = ~pending_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Randomised bench for test_pattern_gen against a behavioural model
// built from frame counts and pixel arithmetic.
module tb_test_pattern_gen;

  localparam int FW   = 858;
  localparam int FH   = 525;
  localparam int SW   = 720;
  localparam int SH   = 480;
  localparam int SX   = FW-SW;
  localparam int SY   = FH-SH;
  localparam int STEP = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  cx = '0;
  logic [9:0]  cy = '0;
  logic [2:0]  req = '0;
  logic        vld = 1'b0;
  logic [23:0] solid = '0;
  logic        ready;
  logic [23:0] rgb;
  logic [2:0]  mode_active;
  logic        frame_start;
  logic [7:0]  frame_count;

  test_pattern_gen #(.SCROLL_STEP(STEP)) dut (
    .clk_pixel(clk), .reset_n(rst_n), .cx(cx), .cy(cy),
    .mode_req(req), .mode_valid(vld), .mode_ready(ready),
    .solid_rgb(solid), .rgb(rgb), .mode_active(mode_active),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int m_mode, m_pend, m_pmode, m_frames, m_run;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bar_color(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] exp_rgb(
    input int px, input int py, input int mode,
    input int frames, input int run, input logic [23:0] sol);
    int x, y, s, b;
    if (mode == 0) begin
      return {(px == SX) ? 8'hFF : 8'h00,
              (py == SY) ? 8'hFF : 8'h00,
              (px == FW-1 || py == FH-1) ? 8'hFF : 8'h00};
    end
    if (px < SX || py < SY) return 24'h0;
    x = px - SX;
    y = py - SY;
    s = (frames * STEP) % SW;
    b = run / (SW/8);
    if (b > 7) b = 7;
    case (mode)
      1: return bar_color(b);
      2: return (((x/16) ^ (y/16)) % 2 != 0) ? 24'hFFFFFF : 24'h0;
      3: return {8'(x % 256), 8'(y % 256), 8'h00};
      4: return (x >= s && x < s+8) ? 24'hFFFFFF : 24'h0;
      5: return sol;
      default: return 24'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_pmode = 0;
    m_frames = 0; m_run = 0;
  endtask

  task automatic step(input int px, input int py,
                      input bit v, input int r);
    logic [23:0] e;
    bit fb;
    cx  = 10'(px);
    cy  = 10'(py);
    vld = v;
    req = 3'(r);
    e  = exp_rgb(px, py, m_mode, m_frames, m_run, solid);
    fb = (px == 0 && py == 0);
    if (m_pend != 0) begin
      if (fb) begin
        m_mode = m_pmode;
        m_pend = 0;
      end
    end else if (v) begin
      m_pend  = 1;
      m_pmode = r;
    end
    if (fb) m_frames++;
    m_run = (px >= SX) ? m_run + 1 : 0;
    @(posedge clk);
    #1;
    check("rgb", 32'(rgb), 32'(e));
    check("mode", 32'(mode_active), 32'(m_mode));
    check("ready", 32'(ready), 32'(m_pend == 0));
    check("fstart", 32'(frame_start), 32'(fb));
    check("fcount", 32'(frame_count), 32'(m_frames % 256));
  endtask

  initial begin
    int rx, ry, s, lo, hi;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rgb", 32'(rgb), 32'h0);
    check("rst_mode", 32'(mode_active), 32'h0);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_fs", 32'(frame_start), 32'h0);
    check("rst_fc", 32'(frame_count), 32'h0);
    rst_n = 1'b1;

    // border mode
    step(0, 0, 0, 0);
    step(138, 45, 0, 0);
    check("t1_138_45", 32'(rgb), 32'hFFFF00);
    step(857, 300, 0, 0);
    check("t1_857_300", 32'(rgb), 32'h0000FF);
    step(857, 524, 0, 0);
    check("t1_857_524", 32'(rgb), 32'h0000FF);
    step(300, 300, 0, 0);
    check("t1_300_300", 32'(rgb), 32'h0);
    step(0, 0, 0, 0);
    check("t1_0_0", 32'(rgb), 32'h0);

    // colour bars over one whole line
    step(5, 10, 1, 1);
    step(0, 0, 0, 0);
    check("t2_mode", 32'(mode_active), 32'd1);
    for (int x = 0; x < FW; x++) begin
      step(x, 100, 0, 0);
      if (x == SX)     check("t2_x0", 32'(rgb), 32'hFFFFFF);
      if (x == SX+89)  check("t2_x89", 32'(rgb), 32'hFFFFFF);
      if (x == SX+90)  check("t2_x90", 32'(rgb), 32'hFFFF00);
      if (x == SX+629) check("t2_x629", 32'(rgb), 32'h0000FF);
      if (x == SX+630) check("t2_x630", 32'(rgb), 32'h0);
      if (x == SX+719) check("t2_x719", 32'(rgb), 32'h0);
    end

    // request while pending is dropped
    step(200, 50, 1, 2);
    check("t3_ready_low", 32'(ready), 32'h0);
    step(201, 50, 1, 4);
    step(202, 50, 0, 0);
    step(0, 0, 0, 0);
    check("t3_mode", 32'(mode_active), 32'd2);
    check("t3_ready_hi", 32'(ready), 32'h1);

    // request in the frame-boundary cycle
    step(0, 0, 1, 3);
    check("t4_same", 32'(mode_active), 32'd2);
    for (int i = 0; i < 20; i++)
      step($urandom_range(SX, FW-1), $urandom_range(SY, FH-1), 0, 0);
    step(0, 0, 0, 0);
    check("t4_next", 32'(mode_active), 32'd3);

    // moving bar and frame counter wrap
    step(10, 10, 1, 4);
    step(0, 0, 0, 0);
    for (int f = 0; f < 300; f++) begin
      step(0, 0, 0, 0);
      if (m_frames == 256) check("t5_wrap", 32'(frame_count), 32'h0);
      s  = (m_frames * STEP) % SW;
      lo = (s > 2) ? s - 2 : 0;
      hi = (s + 9 < SW) ? s + 9 : SW - 1;
      for (int x = lo; x <= hi; x++) step(SX + x, SY + 5, 0, 0);
    end

    // random raster with jumps, boundaries and requests
    rx = 0;
    ry = 0;
    for (int i = 0; i < 4000; i++) begin
      solid = 24'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        rx = 0;
        ry = 0;
      end else if ($urandom_range(0, 99) == 0) begin
        rx = $urandom_range(0, FW-1);
        ry = $urandom_range(0, FH-1);
      end else begin
        rx++;
        if (rx == FW) begin
          rx = 0;
          ry = (ry + 1) % FH;
        end
      end
      step(rx, ry, $urandom_range(0, 19) == 0, $urandom_range(0, 7));
    end

    // reset mid-line with a request pending
    step(0, 0, 0, 0);
    step(10, 10, 1, 5);
    step(0, 0, 0, 0);
    solid = 24'h123456;
    step(SX+10, SY+10, 0, 0);
    step(SX+11, SY+10, 1, 2);
    step(SX+12, SY+10, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rgb", 32'(rgb), 32'h0);
    check("t6_mode", 32'(mode_active), 32'h0);
    check("t6_ready", 32'(ready), 32'h1);
    check("t6_fc", 32'(frame_count), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(0, 0, 0, 0);
    check("t6_no_apply", 32'(mode_active), 32'h0);
    step(SX+1, SY+1, 0, 0);
    step(0, 0, 0, 0);
    check("t6_no_apply2", 32'(mode_active), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
